// File: rtl/alu8_pkg.sv
// alu8_pkg: shared types and ALU8 mode encodings
// for the nibble-serial ALU8 operation sequencer.
package alu8_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LO_SEL = 2'b00;
  localparam logic [1:0] MODE_HI_SEL = 2'b01;

  // ALU8 inverts the nibble select for SUB
  function automatic logic [3:0] alu8_mode(
    input op_t  op,
    input logic hi_pass
  );
    logic [1:0] sel;
    sel = hi_pass ? MODE_HI_SEL : MODE_LO_SEL;
    if (op == OP_SUB)
      sel = hi_pass ? MODE_LO_SEL : MODE_HI_SEL;
    return {sel, op};
  endfunction

endpackage

// File: rtl/alu8_op_sequencer_merge.sv
// alu8_nibble_merge: folds the low-pass carry/borrow
// into the high nibble and forms the final flag.
module alu8_nibble_merge
  import alu8_pkg::*;
(
  input  op_t        op,
  input  logic [3:0] h,
  input  logic       c,
  input  logic       r4,
  output logic [3:0] hi,
  output logic       cflag
);

  // apply low-pass carry/borrow to the high nibble
  always_comb begin
    hi    = h;
    cflag = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        hi    = h + {3'b000, c};
        cflag = r4 | ((h == 4'hF) & c);
      end
      (op == OP_SUB): begin
        hi    = h - {3'b000, c};
        cflag = r4 | ((h == 4'h0) & c);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu8_op_sequencer.sv
// alu8_op_sequencer: runs an 8-bit op through the
// nibble-wide ALU8 as a low pass then a high pass.
module alu8_op_sequencer
  import alu8_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] alu_left,
  output logic [7:0] alu_right,
  output logic [3:0] alu_mode,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_cflag,
  output logic       rsp_zflag
);

  localparam logic [3:0] SETTLE_N = 4'(SETTLE);

  state_t     state;
  state_t     state_n;
  op_t        op_q;
  logic [3:0] cnt;
  logic [3:0] lo_q;
  logic       c_q;

  logic       pass_last;
  logic       accept;
  logic       lo_done;
  logic       hi_done;
  logic       arith;
  logic [3:0] hi_nib;
  logic       hi_flag;
  logic       unused_res;

  assign pass_last  = (cnt == SETTLE_N);
  assign arith      = (op_q == OP_ADD) |
                      (op_q == OP_SUB);
  assign unused_res = ^alu_result[7:5];

  alu8_nibble_merge u_merge (
    .op    (op_q),
    .h     (alu_result[3:0]),
    .c     (c_q),
    .r4    (alu_result[4]),
    .hi    (hi_nib),
    .cflag (hi_flag)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (req_valid & req_ready)
                 state_n = ST_LO;
      ST_LO:   if (pass_last)
                 state_n = ST_HI;
      ST_HI:   if (pass_last)
                 state_n = ST_RSP;
      ST_RSP:  if (rsp_ready)
                 state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // per-state strobes for the datapath
  always_comb begin
    accept  = 1'b0;
    lo_done = 1'b0;
    hi_done = 1'b0;
    unique case (state)
      ST_IDLE: accept  = req_valid & req_ready;
      ST_LO:   lo_done = pass_last;
      ST_HI:   hi_done = pass_last;
      default: ;
    endcase
  end

  // registered datapath and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      op_q      <= OP_ADD;
      cnt       <= 4'd0;
      lo_q      <= 4'd0;
      c_q       <= 1'b0;
      alu_left  <= 8'h00;
      alu_right <= 8'h00;
      alu_mode  <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_cflag <= 1'b0;
      rsp_zflag <= 1'b0;
    end else begin
      req_ready <= (state_n == ST_IDLE);
      if (state_n != state)
        cnt <= 4'd0;
      else if ((state == ST_LO) |
               (state == ST_HI))
        cnt <= cnt + 4'd1;
      if (accept) begin
        op_q      <= op_t'(req_op);
        alu_left  <= req_a;
        alu_right <= req_b;
        alu_mode  <= alu8_mode(
                       op_t'(req_op), 1'b0);
      end
      if (lo_done) begin
        lo_q     <= alu_result[3:0];
        c_q      <= arith & alu_result[4];
        alu_mode <= alu8_mode(op_q, 1'b1);
      end
      if (hi_done) begin
        rsp_data  <= {hi_nib, lo_q};
        rsp_cflag <= hi_flag;
        rsp_zflag <= ({hi_nib, lo_q} == 8'h00);
        rsp_valid <= 1'b1;
      end
      if ((state == ST_RSP) & rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu8_op_sequencer.sv
// tb_alu8_op_sequencer: directed vectors through two
// sequencers (SETTLE 0 and 3) each driving an ALU8 model.
module tb_alu8_op_sequencer;

  logic       clk;
  logic       rst_n;

  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a, req_b;
  logic [7:0] alu_left, alu_right, alu_result;
  logic [3:0] alu_mode;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cflag, rsp_zflag;

  logic       req_valid3, req_ready3;
  logic [1:0] req_op3;
  logic [7:0] req_a3, req_b3;
  logic [7:0] alu_left3, alu_right3, alu_result3;
  logic [3:0] alu_mode3;
  logic       rsp_valid3, rsp_ready3;
  logic [7:0] rsp_data3;
  logic       rsp_cflag3, rsp_zflag3;
  logic       glitch;

  int vectors;
  int miscompares;

  // ALU8 behaviour: one nibble per pass, SUB select inverted
  function automatic logic [7:0] alu8(
    input logic [7:0] l,
    input logic [7:0] r,
    input logic [3:0] m
  );
    logic       hs;
    logic [3:0] x, y;
    logic [4:0] s;
    hs = (m[1:0] == 2'd1) ? ~m[2] : m[2];
    x  = hs ? l[7:4] : l[3:0];
    y  = hs ? r[7:4] : r[3:0];
    case (m[1:0])
      2'd0:    s = {1'b0, x} + {1'b0, y};
      2'd1:    s = {1'b0, x} - {1'b0, y};
      2'd2:    s = {1'b0, x & y};
      default: s = {1'b0, x | y};
    endcase
    return {3'b101, s};
  endfunction

  assign alu_result  = alu8(alu_left, alu_right, alu_mode);
  assign alu_result3 = glitch ? 8'hE7 :
                       alu8(alu_left3, alu_right3, alu_mode3);

  alu8_op_sequencer #(.SETTLE(0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_left   (alu_left),
    .alu_right  (alu_right),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cflag  (rsp_cflag),
    .rsp_zflag  (rsp_zflag)
  );

  alu8_op_sequencer #(.SETTLE(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid3),
    .req_ready  (req_ready3),
    .req_op     (req_op3),
    .req_a      (req_a3),
    .req_b      (req_b3),
    .alu_left   (alu_left3),
    .alu_right  (alu_right3),
    .alu_mode   (alu_mode3),
    .alu_result (alu_result3),
    .rsp_valid  (rsp_valid3),
    .rsp_ready  (rsp_ready3),
    .rsp_data   (rsp_data3),
    .rsp_cflag  (rsp_cflag3),
    .rsp_zflag  (rsp_zflag3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk8(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(
    input string tag,
    input logic  obs,
    input logic  exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // one request on the SETTLE=0 unit, rsp_ready held high
  task automatic do_op(
    input string      tag,
    input logic [1:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] ed,
    input logic       ec,
    input logic       ez,
    input logic [3:0] mlo,
    input logic [3:0] mhi
  );
    @(negedge clk);
    req_op = op; req_a = a; req_b = b;
    req_valid = 1'b1;
    chk1({tag, "_rdy"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk8({tag, "_left"}, alu_left, a);
    chk8({tag, "_right"}, alu_right, b);
    chk8({tag, "_mlo"}, {4'h0, alu_mode}, {4'h0, mlo});
    chk1({tag, "_busy"}, req_ready, 1'b0);
    chk1({tag, "_v1"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk8({tag, "_mhi"}, {4'h0, alu_mode}, {4'h0, mhi});
    chk1({tag, "_v2"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk1({tag, "_valid"}, rsp_valid, 1'b1);
    chk8({tag, "_data"}, rsp_data, ed);
    chk1({tag, "_cflag"}, rsp_cflag, ec);
    chk1({tag, "_zflag"}, rsp_zflag, ez);
    @(negedge clk);
    chk1({tag, "_drop"}, rsp_valid, 1'b0);
    chk1({tag, "_rdy2"}, req_ready, 1'b1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; glitch = 1'b0;
    req_valid = 1'b0; req_op = 2'd0;
    req_a = 8'h00; req_b = 8'h00;
    rsp_ready = 1'b1;
    req_valid3 = 1'b0; req_op3 = 2'd0;
    req_a3 = 8'h00; req_b3 = 8'h00;
    rsp_ready3 = 1'b0;

    repeat (2) @(negedge clk);
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_valid", rsp_valid, 1'b0);
    chk8("rst_data", rsp_data, 8'h00);
    chk1("rst_cflag", rsp_cflag, 1'b0);
    chk1("rst_zflag", rsp_zflag, 1'b0);
    chk8("rst_left", alu_left, 8'h00);
    chk8("rst_right", alu_right, 8'h00);
    chk8("rst_mode", {4'h0, alu_mode}, 8'h00);
    rst_n = 1'b1;

    do_op("add1", 2'd0, 8'h3A, 8'h47,
          8'h81, 1'b0, 1'b0, 4'b0000, 4'b0100);
    do_op("addz", 2'd0, 8'hFF, 8'h01,
          8'h00, 1'b1, 1'b1, 4'b0000, 4'b0100);
    do_op("addcp", 2'd0, 8'h88, 8'h78,
          8'h00, 1'b1, 1'b1, 4'b0000, 4'b0100);
    do_op("sub1", 2'd1, 8'h10, 8'h01,
          8'h0F, 1'b0, 1'b0, 4'b0101, 4'b0001);
    do_op("subb", 2'd1, 8'h00, 8'h01,
          8'hFF, 1'b1, 1'b0, 4'b0101, 4'b0001);
    do_op("sub3", 2'd1, 8'h80, 8'h01,
          8'h7F, 1'b0, 1'b0, 4'b0101, 4'b0001);
    do_op("and1", 2'd2, 8'hF0, 8'h3C,
          8'h30, 1'b0, 1'b0, 4'b0010, 4'b0110);
    do_op("or1", 2'd3, 8'h0A, 8'h50,
          8'h5A, 1'b0, 1'b0, 4'b0011, 4'b0111);

    // backpressure: first response held, second request waits
    @(negedge clk);
    rsp_ready = 1'b0;
    req_op = 2'd0; req_a = 8'h12; req_b = 8'h34;
    req_valid = 1'b1;
    @(negedge clk);
    req_op = 2'd1; req_a = 8'h55; req_b = 8'h23;
    @(negedge clk);
    @(negedge clk);
    chk1("bp_valid", rsp_valid, 1'b1);
    chk8("bp_data", rsp_data, 8'h46);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_hold_v", rsp_valid, 1'b1);
      chk8("bp_hold_d", rsp_data, 8'h46);
      chk1("bp_hold_c", rsp_cflag, 1'b0);
      chk1("bp_hold_rdy", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk1("bp_drop", rsp_valid, 1'b0);
    chk1("bp_rdy", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk8("bp2_left", alu_left, 8'h55);
    chk8("bp2_mode", {4'h0, alu_mode}, 8'h05);
    @(negedge clk);
    @(negedge clk);
    chk1("bp2_valid", rsp_valid, 1'b1);
    chk8("bp2_data", rsp_data, 8'h32);
    chk1("bp2_cflag", rsp_cflag, 1'b0);
    @(negedge clk);
    chk1("bp2_drop", rsp_valid, 1'b0);

    // SETTLE=3: garbage on alu_result except sample cycles
    @(negedge clk);
    req_op3 = 2'd0; req_a3 = 8'h3A; req_b3 = 8'h47;
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    glitch = 1'b1;
    repeat (3) @(negedge clk);
    glitch = 1'b0;
    chk8("s3_mlo", {4'h0, alu_mode3}, 8'h00);
    @(negedge clk);
    glitch = 1'b1;
    chk8("s3_mhi", {4'h0, alu_mode3}, 8'h04);
    chk1("s3_v4", rsp_valid3, 1'b0);
    repeat (3) @(negedge clk);
    glitch = 1'b0;
    chk1("s3_v7", rsp_valid3, 1'b0);
    @(negedge clk);
    chk1("s3_valid", rsp_valid3, 1'b1);
    chk8("s3_data", rsp_data3, 8'h81);
    chk1("s3_cflag", rsp_cflag3, 1'b0);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    chk1("s3_drop", rsp_valid3, 1'b0);
    chk1("s3_rdy", req_ready3, 1'b1);

    // asynchronous reset while in the high pass
    @(negedge clk);
    req_op = 2'd0; req_a = 8'hFF; req_b = 8'h01;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk8("ar_mode_pre", {4'h0, alu_mode}, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_ready", req_ready, 1'b1);
    chk1("ar_valid", rsp_valid, 1'b0);
    chk8("ar_data", rsp_data, 8'h00);
    chk8("ar_left", alu_left, 8'h00);
    chk8("ar_right", alu_right, 8'h00);
    chk8("ar_mode", {4'h0, alu_mode}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("ar_norsp", rsp_valid, 1'b0);
    end
    do_op("ar_or", 2'd3, 8'h0A, 8'h50,
          8'h5A, 1'b0, 1'b0, 4'b0011, 4'b0111);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
